// File: rtl/lsu_mem_access_if.sv
// Word-wide data-memory request/response bus between the LSU and the memory.
interface lsu_mem_access_if;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/lsu_mem_access.sv
// Load/store access unit: legality check, byte-lane steering, load extension
// and a request/done handshake towards a variable-latency word memory.
module lsu_mem_access #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     DMWr,
    input  logic [2:0]               DMCtrl,
    input  logic [31:0]              Address,
    input  logic [31:0]              DataWr,
    output logic [31:0]              DataRd,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    lsu_mem_access_if.master         mem
);

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_pending_q, err_pending_d;
    logic        we_q;
    logic [2:0]  ctrl_q;
    logic [1:0]  off_q;
    logic [29:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] datard_q;
    logic        busy_q, done_q, err_q, req_q;

    logic        legal;
    logic        capture;
    logic        load_upd;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] lane;
    logic [31:0] load_ext;

    // Decide whether the requested access may reach memory at all.
    always_comb begin
        legal = 1'b0;
        case (DMCtrl)
            3'b000, 3'b100: legal = 1'b1;
            3'b001, 3'b101: legal = ~Address[0];
            3'b010:         legal = (Address[1:0] == 2'b00);
            default:        legal = 1'b0;
        endcase
        // Unsigned variants only make sense for loads.
        if (DMWr && DMCtrl[2]) begin
            legal = 1'b0;
        end
    end

    // Byte enables and lane-replicated store data for the incoming access.
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = DataWr;
        case (DMCtrl[1:0])
            2'b00: begin
                be_new    = 4'b0001 << Address[1:0];
                wdata_new = {4{DataWr[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << Address[1:0];
                wdata_new = {2{DataWr[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = DataWr;
            end
        endcase
    end

    // Shift the addressed lane down and sign/zero-extend it.
    always_comb begin
        lane     = mem.mem_rdata >> {off_q, 3'b000};
        load_ext = lane;
        case (ctrl_q)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_ext = {24'h0, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_ext = {16'h0, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    // Next-state logic for the access FSM and its wait counter.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_pending_d = err_pending_q;
        capture       = 1'b0;
        load_upd      = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (legal) begin
                        state_d       = StAccess;
                        cnt_d         = 8'd0;
                        err_pending_d = 1'b0;
                        capture       = 1'b1;
                    end else begin
                        state_d       = StResp;
                        err_pending_d = 1'b1;
                    end
                end
            end
            StAccess: begin
                cnt_d = cnt_q + 8'd1;
                // A response in the last allowed cycle still counts as success.
                if (mem.mem_ready) begin
                    state_d       = StResp;
                    err_pending_d = 1'b0;
                    load_upd      = ~we_q;
                end else if (cnt_q == TimeoutLast) begin
                    state_d       = StResp;
                    err_pending_d = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, captured request fields and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= 8'd0;
            err_pending_q <= 1'b0;
            we_q          <= 1'b0;
            ctrl_q        <= 3'b000;
            off_q         <= 2'b00;
            addr_q        <= 30'd0;
            be_q          <= 4'b0000;
            wdata_q       <= 32'd0;
            datard_q      <= 32'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            req_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            err_pending_q <= err_pending_d;
            if (capture) begin
                we_q    <= DMWr;
                ctrl_q  <= DMCtrl;
                off_q   <= Address[1:0];
                addr_q  <= Address[31:2];
                be_q    <= be_new;
                wdata_q <= wdata_new;
            end
            if (load_upd) begin
                datard_q <= load_ext;
            end
            busy_q <= (state_d != StIdle);
            done_q <= (state_d == StResp);
            err_q  <= (state_d == StResp) && err_pending_d;
            req_q  <= (state_d == StAccess);
        end
    end

    assign DataRd        = datard_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access with a completion scoreboard.
module tb_lsu_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        DMWr;
    logic [2:0]  DMCtrl;
    logic [31:0] Address;
    logic [31:0] DataWr;
    logic [31:0] DataRd;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          lat;
        int          reqs;
    } exp_t;

    exp_t sb[$];

    lsu_mem_access_if mif ();

    lsu_mem_access #(
        .TIMEOUT (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .DMWr    (DMWr),
        .DMCtrl  (DMCtrl),
        .Address (Address),
        .DataWr  (DataWr),
        .DataRd  (DataRd),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .mem     (mif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one access from a post-edge point; ready_delay < 0 means never ready.
    task automatic do_access(
        input string       tag,
        input logic        we,
        input logic [2:0]  ctrl,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [31:0] rdata,
        input int          ready_delay,
        input logic [29:0] e_addr,
        input logic [3:0]  e_be,
        input logic [31:0] e_wdata,
        input int          e_reqs,
        input int          e_lat,
        input logic        e_err,
        input logic [31:0] e_data
    );
        exp_t e;
        int   nreq;
        bit   got;
        sb.push_back('{err: e_err, data: e_data, lat: e_lat, reqs: e_reqs});
        DMWr          = we;
        DMCtrl        = ctrl;
        Address       = addr;
        DataWr        = wdata;
        mif.mem_rdata = rdata;
        start         = 1'b1;
        nreq          = 0;
        got           = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (mif.mem_req) begin
                if (nreq == 0) begin
                    check({tag, "_addr"}, 32'(mif.mem_addr), 32'(e_addr));
                    check({tag, "_be"}, 32'(mif.mem_be), 32'(e_be));
                    check({tag, "_wdata"}, mif.mem_wdata, e_wdata);
                    check({tag, "_we"}, 32'(mif.mem_we), 32'(we));
                end
                mif.mem_ready = (nreq == ready_delay);
                nreq++;
            end else begin
                mif.mem_ready = 1'b0;
            end
            if (done) begin
                got = 1'b1;
                e   = sb.pop_front();
                check({tag, "_err"}, 32'(err), 32'(e.err));
                check({tag, "_datard"}, DataRd, e.data);
                check({tag, "_latency"}, 32'(c), 32'(e.lat));
                check({tag, "_reqcycles"}, 32'(nreq), 32'(e.reqs));
            end
        end
        if (!got) begin
            check({tag, "_done_seen"}, 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        @(posedge clk);
        #1;
        check({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        DMWr          = 1'b0;
        DMCtrl        = 3'b000;
        Address       = 32'd0;
        DataWr        = 32'd0;
        mif.mem_rdata = 32'd0;
        mif.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_datard", DataRd, 32'd0);
        check("rst_flags", {27'd0, busy, done, err, mif.mem_req, mif.mem_we}, 32'd0);
        check("rst_addr", 32'(mif.mem_addr), 32'd0);
        check("rst_be_wdata", mif.mem_wdata | 32'(mif.mem_be), 32'd0);
        rst = 1'b0;

        do_access("sw", 1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 0,
                  30'h401, 4'b1111, 32'hDEAD_BEEF, 1, 2, 1'b0, 32'h0);
        do_access("lb", 1'b0, 3'b000, 32'h0000_2003, 32'h0, 32'h80FF_0000, 0,
                  30'h800, 4'b1000, 32'h0, 1, 2, 1'b0, 32'hFFFF_FF80);
        do_access("lbu", 1'b0, 3'b100, 32'h0000_2003, 32'h0, 32'h80FF_0000, 0,
                  30'h800, 4'b1000, 32'h0, 1, 2, 1'b0, 32'h0000_0080);
        do_access("sh", 1'b1, 3'b001, 32'h0000_3002, 32'h1234_ABCD, 32'h0, 0,
                  30'hC00, 4'b1100, 32'hABCD_ABCD, 1, 2, 1'b0, 32'h0000_0080);
        do_access("lhu", 1'b0, 3'b101, 32'h0000_3002, 32'h0, 32'hABCD_0000, 0,
                  30'hC00, 4'b1100, 32'h0, 1, 2, 1'b0, 32'h0000_ABCD);
        do_access("lw_mis", 1'b0, 3'b010, 32'h0000_3002, 32'h0, 32'hFFFF_FFFF, 0,
                  30'h0, 4'b0, 32'h0, 0, 1, 1'b1, 32'h0000_ABCD);
        do_access("ctrl011", 1'b0, 3'b011, 32'h0000_3000, 32'h0, 32'hFFFF_FFFF, 0,
                  30'h0, 4'b0, 32'h0, 0, 1, 1'b1, 32'h0000_ABCD);
        do_access("lh_wait2", 1'b0, 3'b001, 32'h0000_4000, 32'h0, 32'h0000_8001, 2,
                  30'h1000, 4'b0011, 32'h0, 3, 4, 1'b0, 32'hFFFF_8001);
        do_access("lw_tmo", 1'b0, 3'b010, 32'h0000_0020, 32'h0, 32'h1111_1111, -1,
                  30'h8, 4'b1111, 32'h0, 4, 5, 1'b1, 32'hFFFF_8001);
        do_access("lw_last", 1'b0, 3'b010, 32'h0000_0024, 32'h0, 32'h1357_2468, 3,
                  30'h9, 4'b1111, 32'h0, 4, 5, 1'b0, 32'h1357_2468);
        do_access("sb", 1'b1, 3'b000, 32'h0000_5001, 32'h0000_00A5, 32'h0, 0,
                  30'h1400, 4'b0010, 32'hA5A5_A5A5, 1, 2, 1'b0, 32'h1357_2468);
        do_access("sbu_ill", 1'b1, 3'b100, 32'h0000_5000, 32'h0000_00A5, 32'h0, 0,
                  30'h0, 4'b0, 32'h0, 0, 1, 1'b1, 32'h1357_2468);

        // Abort a load in its second request cycle with a synchronous reset.
        DMWr          = 1'b0;
        DMCtrl        = 3'b010;
        Address       = 32'h0000_0040;
        mif.mem_ready = 1'b0;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_req_before", 32'(mif.mem_req), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_flags", {29'd0, mif.mem_req, busy, done}, 32'd0);
        check("rst_mid_datard", DataRd, 32'd0);
        @(posedge clk);
        #1;
        check("rst_mid_no_done", {30'd0, busy, done}, 32'd0);

        do_access("lw_after_rst", 1'b0, 3'b010, 32'h0000_0060, 32'h0, 32'hCAFE_F00D, 1,
                  30'h18, 4'b1111, 32'h0, 2, 3, 1'b0, 32'hCAFE_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
